gpio_pad_cfg: RTL and testbench

GPIO_PAD_CFG -- requirements
Module: gpio_pad_cfg

---
 rtl/gpio_cfg_pkg.sv | 46 ++++
 rtl/gpio_cfg_shift.sv | 59 +++++
 rtl/gpio_pad_cfg.sv | 81 ++++++++
 tb/tb_gpio_pad_cfg.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared constants for the GPIO pad configuration block: shadow bit map,
// reset word, drive-mode encodings and the shift-register fill classifier.
package gpio_cfg_pkg;

  localparam int CFG_WIDTH = 13;
  localparam logic [CFG_WIDTH-1:0] RESET_CFG = 13'h0403;

  localparam int BIT_MGMT_EN     = 0;
  localparam int BIT_OEB_CFG     = 1;
  localparam int BIT_HOLDOVER    = 2;
  localparam int BIT_INP_DIS     = 3;
  localparam int BIT_IB_MODE_SEL = 4;
  localparam int BIT_ANALOG_EN   = 5;
  localparam int BIT_ANALOG_SEL  = 6;
  localparam int BIT_ANALOG_POL  = 7;
  localparam int BIT_SLOW_SEL    = 8;
  localparam int BIT_VTRIP_SEL   = 9;
  localparam int BIT_DM_LO       = 10;
  localparam int BIT_DM_HI       = 12;

  localparam logic [2:0] DM_INPUT  = 3'b001;
  localparam logic [2:0] DM_STRONG = 3'b110;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL,
    FILL_OVER
  } fill_state_t;

  // Classifies the shift count against the configured word length.
  function automatic fill_state_t fill_state(input logic [CNT_WIDTH-1:0] cnt,
                                             input logic [CNT_WIDTH-1:0] full);
    if (cnt == '0)
      return FILL_EMPTY;
    else if (cnt < full)
      return FILL_PARTIAL;
    else if (cnt == full)
      return FILL_FULL;
    else
      return FILL_OVER;
  endfunction

endpackage

// File: rtl/gpio_cfg_shift.sv
// Serial configuration shifter: shift register, saturating bit counter,
// registered daisy-chain output and commit/status pulses.
module gpio_cfg_shift #(
  parameter int CFG_WIDTH = gpio_cfg_pkg::CFG_WIDTH
) (
  input  logic                 clk,
  input  logic                 RSTB,
  input  logic                 serial_data_in,
  input  logic                 serial_shift_en,
  input  logic                 serial_load,
  output logic                 serial_data_out,
  output logic                 load_ok,
  output logic                 load_err,
  output logic [CFG_WIDTH-1:0] o_sreg,
  output logic                 o_commit
);
  import gpio_cfg_pkg::*;

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(CFG_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [CFG_WIDTH-1:0] r_sreg;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_sdo;
  logic                 r_ok;
  logic                 r_err;
  fill_state_t          w_fill;

  assign w_fill   = fill_state(r_cnt, FULL_CNT);
  // A load wins over a simultaneous shift, so it judges the pre-shift count.
  assign o_commit = serial_load && (w_fill == FILL_FULL);

  always_ff @(posedge clk) begin
    if (RSTB) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_sdo  <= 1'b0;
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_ok  <= o_commit;
      r_err <= serial_load && !o_commit;
      if (serial_load) begin
        r_cnt <= '0;
      end else if (serial_shift_en) begin
        r_sreg <= {r_sreg[CFG_WIDTH-2:0], serial_data_in};
        r_sdo  <= r_sreg[CFG_WIDTH-1];
        if (r_cnt != CNT_MAX)
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign serial_data_out = r_sdo;
  assign load_ok         = r_ok;
  assign load_err        = r_err;
  assign o_sreg          = r_sreg;

endmodule

// File: rtl/gpio_pad_cfg.sv
// Per-pad configuration block: serially loaded shadow register driving the
// static pad controls, plus the management/user ownership mux.
module gpio_pad_cfg #(
  parameter int                   CFG_WIDTH = gpio_cfg_pkg::CFG_WIDTH,
  parameter logic [CFG_WIDTH-1:0] RESET_CFG = gpio_cfg_pkg::RESET_CFG
) (
  input  logic       clk,
  input  logic       RSTB,
  input  logic       serial_data_in,
  input  logic       serial_shift_en,
  input  logic       serial_load,
  output logic       serial_data_out,
  output logic       load_ok,
  output logic       load_err,
  input  logic       mgmt_out,
  input  logic       mgmt_oeb,
  input  logic       user_out,
  input  logic       user_oeb,
  input  logic       pad_in,
  output logic       mgmt_in,
  output logic       user_in,
  output logic       pad_out,
  output logic       pad_oeb,
  output logic [2:0] pad_dm,
  output logic       pad_inp_dis,
  output logic       pad_ib_mode_sel,
  output logic       pad_vtrip_sel,
  output logic       pad_slow_sel,
  output logic       pad_holdover,
  output logic       pad_analog_en,
  output logic       pad_analog_sel,
  output logic       pad_analog_pol
);
  import gpio_cfg_pkg::*;

  logic [CFG_WIDTH-1:0] r_shadow;
  logic [CFG_WIDTH-1:0] w_sreg;
  logic                 w_commit;
  logic                 w_mgmt_en;

  gpio_cfg_shift #(
    .CFG_WIDTH(CFG_WIDTH)
  ) u_shift (
    .clk             (clk),
    .RSTB            (RSTB),
    .serial_data_in  (serial_data_in),
    .serial_shift_en (serial_shift_en),
    .serial_load     (serial_load),
    .serial_data_out (serial_data_out),
    .load_ok         (load_ok),
    .load_err        (load_err),
    .o_sreg          (w_sreg),
    .o_commit        (w_commit)
  );

  always_ff @(posedge clk) begin
    if (RSTB)
      r_shadow <= RESET_CFG;
    else if (w_commit)
      r_shadow <= w_sreg;
  end

  assign w_mgmt_en = r_shadow[BIT_MGMT_EN];

  // Ownership mux; the management side can force tri-state via oeb_cfg.
  assign pad_out = w_mgmt_en ? mgmt_out : user_out;
  assign pad_oeb = w_mgmt_en ? (mgmt_oeb | r_shadow[BIT_OEB_CFG]) : user_oeb;
  assign mgmt_in = w_mgmt_en & pad_in;
  assign user_in = !w_mgmt_en & pad_in;

  assign pad_dm          = r_shadow[BIT_DM_HI:BIT_DM_LO];
  assign pad_inp_dis     = r_shadow[BIT_INP_DIS];
  assign pad_ib_mode_sel = r_shadow[BIT_IB_MODE_SEL];
  assign pad_vtrip_sel   = r_shadow[BIT_VTRIP_SEL];
  assign pad_slow_sel    = r_shadow[BIT_SLOW_SEL];
  assign pad_holdover    = r_shadow[BIT_HOLDOVER];
  assign pad_analog_en   = r_shadow[BIT_ANALOG_EN];
  assign pad_analog_sel  = r_shadow[BIT_ANALOG_SEL];
  assign pad_analog_pol  = r_shadow[BIT_ANALOG_POL];

endmodule

// File: tb/tb_gpio_pad_cfg.sv
// Self-checking bench for gpio_pad_cfg: queue-based reference model, a
// table of ownership-mux vectors, hand-written corner sequences and a chain.
module tb_gpio_pad_cfg;

  localparam int          W         = 13;
  localparam logic [12:0] RESET_WRD = 13'h0403;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic RSTB = 1'b1, sdi = 1'b0, sh = 1'b0, ld = 1'b0;
  logic mo = 1'b0, moe = 1'b0, uo = 1'b0, uoe = 1'b0, pin = 1'b0;
  logic sdo, ok, err, m_in, u_in, p_out, p_oeb;
  logic [2:0] dm;
  logic inp_dis, ibm, vtrip, slow, hold, aen, asel, apol;

  gpio_pad_cfg u_dut (
    .clk(clk), .RSTB(RSTB), .serial_data_in(sdi), .serial_shift_en(sh),
    .serial_load(ld), .serial_data_out(sdo), .load_ok(ok), .load_err(err),
    .mgmt_out(mo), .mgmt_oeb(moe), .user_out(uo), .user_oeb(uoe), .pad_in(pin),
    .mgmt_in(m_in), .user_in(u_in), .pad_out(p_out), .pad_oeb(p_oeb),
    .pad_dm(dm), .pad_inp_dis(inp_dis), .pad_ib_mode_sel(ibm),
    .pad_vtrip_sel(vtrip), .pad_slow_sel(slow), .pad_holdover(hold),
    .pad_analog_en(aen), .pad_analog_sel(asel), .pad_analog_pol(apol)
  );

  // Two-block daisy chain
  logic c_rstb = 1'b1, c_din = 1'b0, c_sh = 1'b0, c_ld = 1'b0, c_pin = 1'b1;
  logic c_mid, c_dn_sdo;
  logic up_ok, up_err, up_min, up_uin, up_pout, up_poeb;
  logic dn_ok, dn_err, dn_min, dn_uin, dn_pout, dn_poeb;
  logic [2:0] up_dm, dn_dm;
  logic [7:0] up_misc, dn_misc;

  gpio_pad_cfg u_up (
    .clk(clk), .RSTB(c_rstb), .serial_data_in(c_din), .serial_shift_en(c_sh),
    .serial_load(c_ld), .serial_data_out(c_mid), .load_ok(up_ok), .load_err(up_err),
    .mgmt_out(1'b0), .mgmt_oeb(1'b0), .user_out(1'b0), .user_oeb(1'b0), .pad_in(c_pin),
    .mgmt_in(up_min), .user_in(up_uin), .pad_out(up_pout), .pad_oeb(up_poeb),
    .pad_dm(up_dm), .pad_inp_dis(up_misc[0]), .pad_ib_mode_sel(up_misc[1]),
    .pad_vtrip_sel(up_misc[2]), .pad_slow_sel(up_misc[3]), .pad_holdover(up_misc[4]),
    .pad_analog_en(up_misc[5]), .pad_analog_sel(up_misc[6]), .pad_analog_pol(up_misc[7])
  );

  gpio_pad_cfg u_dn (
    .clk(clk), .RSTB(c_rstb), .serial_data_in(c_mid), .serial_shift_en(c_sh),
    .serial_load(c_ld), .serial_data_out(c_dn_sdo), .load_ok(dn_ok), .load_err(dn_err),
    .mgmt_out(1'b0), .mgmt_oeb(1'b0), .user_out(1'b0), .user_oeb(1'b0), .pad_in(c_pin),
    .mgmt_in(dn_min), .user_in(dn_uin), .pad_out(dn_pout), .pad_oeb(dn_poeb),
    .pad_dm(dn_dm), .pad_inp_dis(dn_misc[0]), .pad_ib_mode_sel(dn_misc[1]),
    .pad_vtrip_sel(dn_misc[2]), .pad_slow_sel(dn_misc[3]), .pad_holdover(dn_misc[4]),
    .pad_analog_en(dn_misc[5]), .pad_analog_sel(dn_misc[6]), .pad_analog_pol(dn_misc[7])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_load = 0;

  typedef struct packed {
    logic       sdo, ok, err, mgmt_in, user_in, pad_out, pad_oeb;
    logic [2:0] dm;
    logic       inp_dis, ibm, vtrip, slow, hold, aen, asel, apol;
  } obs_t;

  // Reference model: bit history queue (oldest first), shifts since last load.
  bit          m_hist[$];
  int          m_n = 0;
  logic [12:0] m_shadow = RESET_WRD;
  logic        m_sdo = 1'b0, m_ok = 1'b0, m_err = 1'b0;

  task automatic model_step(input logic rst, input logic s, input logic l, input logic d);
    if (rst) begin
      m_hist = {};
      for (int i = 0; i < W; i++) m_hist.push_back(1'b0);
      m_n = 0; m_shadow = RESET_WRD; m_sdo = 0; m_ok = 0; m_err = 0;
    end else if (l) begin
      m_ok  = (m_n == W);
      m_err = !m_ok;
      if (m_ok)
        for (int i = 0; i < W; i++) m_shadow[W-1-i] = m_hist[i];
      m_n = 0;
    end else begin
      m_ok = 0; m_err = 0;
      if (s) begin
        m_sdo = m_hist.pop_front();
        m_hist.push_back(d);
        m_n++;
      end
    end
  endtask

  function automatic obs_t expect_obs();
    obs_t e;
    logic own;
    own       = m_shadow[0];
    e.sdo     = m_sdo;
    e.ok      = m_ok;
    e.err     = m_err;
    e.mgmt_in = own ? pin : 1'b0;
    e.user_in = own ? 1'b0 : pin;
    e.pad_out = own ? mo : uo;
    e.pad_oeb = own ? (moe | m_shadow[1]) : uoe;
    e.dm      = m_shadow[12:10];
    e.inp_dis = m_shadow[3];
    e.ibm     = m_shadow[4];
    e.vtrip   = m_shadow[9];
    e.slow    = m_shadow[8];
    e.hold    = m_shadow[2];
    e.aen     = m_shadow[5];
    e.asel    = m_shadow[6];
    e.apol    = m_shadow[7];
    return e;
  endfunction

  function automatic obs_t got_obs();
    return {sdo, ok, err, m_in, u_in, p_out, p_oeb, dm,
            inp_dis, ibm, vtrip, slow, hold, aen, asel, apol};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_model(input string name);
    obs_t g, e;
    g = got_obs();
    e = expect_obs();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, g, e);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs sampled at the same point.
  task automatic cycle(input logic rst, input logic s, input logic l, input logic d,
                       input string name);
    RSTB = rst; sh = s; ld = l; sdi = d;
    @(posedge clk);
    model_step(rst, s, l, d);
    #1;
    check_model(name);
    if (l && !rst) begin
      n_load++;
      $display("load %0d: load_ok=%b load_err=%b pad_dm=%b", n_load, ok, err, dm);
    end
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b1, 1'b0, w[i], "shift");
  endtask

  task automatic commit_word(input logic [12:0] w);
    shift_bits({19'd0, w}, W);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "commit");
  endtask

  task automatic set_mux(input logic [4:0] v);
    {mo, moe, uo, uoe, pin} = v;
    #1;
  endtask

  typedef struct {
    logic [12:0] cfg;
    logic [4:0]  mux;   // {mgmt_out, mgmt_oeb, user_out, user_oeb, pad_in}
    logic [3:0]  exp;   // {pad_out, pad_oeb, mgmt_in, user_in}
  } vec_t;

  vec_t tbl[6];

  task automatic chain_cycle(input logic s, input logic l, input logic d);
    c_sh = s; c_ld = l; c_din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [12:0] cur_cfg;
    logic [26:0] stream;

    tbl[0] = '{13'h0403, 5'b10011, 4'b1110};
    tbl[1] = '{13'h0403, 5'b01100, 4'b0100};
    tbl[2] = '{13'h0401, 5'b10011, 4'b1010};
    tbl[3] = '{13'h0401, 5'b01100, 4'b0100};
    tbl[4] = '{13'h1800, 5'b00101, 4'b1001};
    tbl[5] = '{13'h1800, 5'b11010, 4'b0100};

    // Reset held for two cycles, then released
    set_mux(5'b00000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "reset0");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "reset1");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    chk("reset_dm", {13'd0, dm}, 16'h0001);
    chk("reset_oeb", {15'd0, p_oeb}, 16'h0001);
    chk("reset_inp_dis", {15'd0, inp_dis}, 16'h0000);
    chk("reset_status", {14'd0, ok, err}, 16'h0000);
    set_mux(5'b00001);
    chk("reset_own", {14'd0, m_in, u_in}, 16'h0002);

    // Commit 13'h1801 and watch mgmt_out on the pad
    shift_bits(32'h1801, W);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "commit_1801");
    chk("commit_ok", {15'd0, ok}, 16'h0001);
    chk("commit_dm", {13'd0, dm}, 16'h0006);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "after_commit");
    chk("commit_ok_once", {15'd0, ok}, 16'h0000);
    set_mux(5'b10000);
    chk("mgmt_toggle_hi", {15'd0, p_out}, 16'h0001);
    set_mux(5'b00000);
    chk("mgmt_toggle_lo", {15'd0, p_out}, 16'h0000);

    // Bad counts: 12, 14 and a wrapping 29 bits must all be refused
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "reset_bad");
    shift_bits(32'h0FFF, 12);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "load_12");
    chk("bad12_err", {15'd0, err}, 16'h0001);
    chk("bad12_dm", {13'd0, dm}, 16'h0001);
    shift_bits(32'h3FFF, 14);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "load_14");
    chk("bad14_err", {15'd0, err}, 16'h0001);
    shift_bits(32'h1FFF_FFFF, 29);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "load_29");
    chk("bad29_err", {15'd0, err}, 16'h0001);

    // Ownership mux vectors, committing each table row's word when it changes
    cur_cfg = 13'h1FFF;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].cfg != cur_cfg) begin
        commit_word(tbl[i].cfg);
        cur_cfg = tbl[i].cfg;
      end
      set_mux(tbl[i].mux);
      chk($sformatf("mux_vec%0d", i), {12'd0, p_out, p_oeb, m_in, u_in},
          {12'd0, tbl[i].exp});
    end

    // Shift and load together in FULL: load wins, count returns to zero
    shift_bits(32'h0A55, W);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, "collide");
    chk("collide_ok", {15'd0, ok}, 16'h0001);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "collide_recheck");
    chk("collide_cnt0", {15'd0, err}, 16'h0001);

    // Reset mid-shift discards the partial word
    shift_bits(32'h001F, 5);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, "reset_midshift");
    set_mux(5'b00000);
    chk("midrst_dm", {13'd0, dm}, 16'h0001);
    chk("midrst_oeb", {15'd0, p_oeb}, 16'h0001);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "load_after_rst");
    chk("midrst_err", {15'd0, err}, 16'h0001);

    // Randomised traffic against the model
    for (int k = 0; k < 15; k++) begin
      commit_word(13'($urandom));
      for (int j = 0; j < 25; j++) begin
        int r;
        r = $urandom_range(0, 99);
        set_mux(5'($urandom));
        cycle(r < 2, r >= 2 && r < 60, r >= 60 && r < 66, 1'($urandom), "random");
      end
    end

    // Chain: each block is W+1 stages (registered output), so a spacer bit
    // sits between the words; a mid-stream load re-arms both counters.
    stream = {13'h1800, 1'b0, 13'h0403};
    chain_cycle(1'b0, 1'b0, 1'b0);
    c_rstb = 1'b0;
    for (int i = 26; i >= 13; i--) chain_cycle(1'b1, 1'b0, stream[i]);
    chain_cycle(1'b0, 1'b1, 1'b0);
    chk("chain_rearm_err", {14'd0, up_err, dn_err}, 16'h0003);
    for (int i = 12; i >= 0; i--) chain_cycle(1'b1, 1'b0, stream[i]);
    chain_cycle(1'b0, 1'b1, 1'b0);
    chk("chain_ok", {14'd0, up_ok, dn_ok}, 16'h0003);
    chain_cycle(1'b0, 1'b0, 1'b0);
    chk("chain_dn_dm", {13'd0, dn_dm}, 16'h0006);
    chk("chain_dn_own", {14'd0, dn_min, dn_uin}, 16'h0001);
    chk("chain_up_dm", {13'd0, up_dm}, 16'h0001);
    chk("chain_up_own", {13'd0, up_min, up_uin, up_poeb}, 16'h0005);
    chk("chain_misc", {up_misc, dn_misc}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
